cache_ctrl_arbiter: RTL and testbench
=====================================

# cache_ctrl_arbiter

Shares one cache controller between `NUM_REQ` OBI cache-interface instances. It captures each interface's one-cycle operation strobe into a per-port pending slot. Pending requests are issued to the controller one at a time in round-robin order. Each controller result is routed back to the originating interface as a one-cycle `ready`/`op_succ`/`value` response, and a watchdog completes stalled operations with a failure.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requester ports; must be ≥2.
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in WAIT before a forced failure; must be ≥1.
- `KEY_WIDTH` and `VALUE_WIDTH`: taken from `if_types_pkg`.

Ports (`[NUM_REQ]` means an unpacked array indexed by port):
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_operation_in[NUM_REQ]` input `ctrl_types_pkg::operation_e`: per-port request strobe; any value ≠ `NOOP` is a request.
- `req_key_in[NUM_REQ]` input `KEY_WIDTH`: key, sampled with the strobe.
- `req_value_in[NUM_REQ]` input `VALUE_WIDTH`: write value, sampled with the strobe.
- `req_ready_out[NUM_REQ]` output 1: one-cycle response pulse.
- `req_op_succ_out[NUM_REQ]` output 1: success flag, valid with `req_ready_out`.
- `req_value_out[NUM_REQ]` output `VALUE_WIDTH`: result value, valid with `req_ready_out`; 0 otherwise.
- `req_overrun_out[NUM_REQ]` output 1: sticky flag; set when a request arrives on a port whose slot is already pending.
- `ctrl_operation_out` output `operation_e`: operation issued to the controller for one cycle; `NOOP` otherwise.
- `ctrl_key_out` output `KEY_WIDTH`: key of the granted request; held from ISSUE through WAIT.
- `ctrl_value_out` output `VALUE_WIDTH`: value of the granted request; held from ISSUE through WAIT.
- `ctrl_ready_in` input 1: controller result-valid.
- `ctrl_op_succ_in` input 1: controller success flag.
- `ctrl_value_in` input `VALUE_WIDTH`: controller read data.

## Operation
**Pending slots**
- Each port has a slot holding `{valid, op, key, value}`.
- A non-`NOOP` strobe on port i with the slot empty loads the slot.
- A non-`NOOP` strobe with the slot already valid is dropped and sets `req_overrun_out[i]`.
- Set has priority over clear: if port i's slot is cleared (its completion in WAIT) in the same cycle that a new strobe arrives on port i, the new request is loaded.

**FSM states**
- IDLE:
  - If any slot is valid, `grant` is set to the first valid index at or above `rr_ptr`, wrapping modulo `NUM_REQ`; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Drive `ctrl_operation_out` with the slot's op for exactly this cycle.
  - Drive key/value from `slot[grant]`.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - `ctrl_operation_out` = `NOOP`; key/value stay held.
  - Watchdog increments each cycle.
  - On `ctrl_ready_in`: latch `ctrl_op_succ_in` and `ctrl_value_in`, clear `slot[grant]`, set `rr_ptr` ← (`grant`+1) mod `NUM_REQ`, go to RESP.
  - If the watchdog reaches `TIMEOUT_CYCLES` without `ctrl_ready_in`: latch succ=0 and value=0, then do the same slot clear, pointer update and move to RESP.
  - If `ctrl_ready_in` and timeout occur in the same cycle, `ctrl_ready_in` wins and the controller data is latched.
- RESP:
  - Drive `req_ready_out[grant]`=1 with the latched succ/value on that port.
  - All other ports read 0; go to IDLE.

**Other rules**
- `ctrl_ready_in` outside WAIT is ignored.
- Watchdog width is `$clog2(TIMEOUT_CYCLES+1)`.
- `grant` and `rr_ptr` are `$clog2(NUM_REQ)` bits wide.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.
- Reset, including mid-operation:
  - State returns to IDLE; all slots, overrun flags, latched data, `rr_ptr`, `grant` and watchdog are cleared.
  - All `req_*` outputs are 0 and `ctrl_operation_out` = `NOOP`; key/value outputs are 0.
  - An in-flight controller result arriving after reset is ignored.

## Timing
- A strobe in cycle T sets its slot at the edge ending T.
- IDLE in T+1 grants; ISSUE in T+2 drives `ctrl_operation_out`.
- The earliest `ctrl_ready_in` is in T+3 (first WAIT cycle), giving `req_ready_out` in T+4.
- Minimum request-to-response latency is 4 cycles. In general it is 3 + (controller wait cycles) + 1.
- A second pending request is granted in the IDLE cycle immediately after RESP.
- Back-to-back service therefore costs 4 cycles of overhead per operation.
- Timeout: with no `ctrl_ready_in`, RESP occurs `TIMEOUT_CYCLES` cycles after the first WAIT cycle.

## Test plan
- Single request: port0 strobes a non-`NOOP` op, key 0x12, value 0xAB in cycle 0; controller returns ready in cycle 3 with succ=1, value 0x55 -> `ctrl_operation_out` is non-`NOOP` in cycle 2 only; `req_ready_out[0]`=1, succ=1, value 0x55 in cycle 4; port1 outputs stay 0.
- Simultaneous requests: ports 0 and 1 strobe in the same cycle after reset -> port0 is issued first, then port1 in the cycle after port0's RESP+IDLE; each response is routed only to its own port.
- Fairness: port0 re-strobes immediately after each response while port1 stays pending -> grants alternate 0,1,0,1 and port1 is never skipped.
- Timeout: `TIMEOUT_CYCLES`=4 and the controller never asserts ready -> `req_ready_out`=1, succ=0, value=0 on the 4th WAIT-cycle edge; a late `ctrl_ready_in` afterwards is ignored.
- Overrun and set-over-clear: port1 strobes twice while pending -> `req_overrun_out[1]`=1 sticky. Separately, a strobe on the same cycle as its slot's completion -> the new request is retained and issued next.
- Reset in WAIT: assert `rst` for one cycle mid-operation -> all outputs 0/`NOOP` the next cycle, no response pulse, and a subsequent fresh request completes normally.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// Operation codes shared between the cache interfaces and the cache controller.
package ctrl_types_pkg;
  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    DELETE = 2'd3
  } operation_e;
endpackage

// File: rtl/if_types_pkg.sv
// Key and value widths of the cache interface.
package if_types_pkg;
  localparam int KEY_WIDTH   = 16;
  localparam int VALUE_WIDTH = 32;
endpackage

// File: rtl/cache_ctrl_arbiter.sv
// Round-robin arbiter that shares one cache controller between NUM_REQ request ports,
// with per-port pending slots, response routing and a WAIT-state watchdog.
module cache_ctrl_arbiter
  import ctrl_types_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int KEY_WIDTH      = if_types_pkg::KEY_WIDTH,
  parameter int VALUE_WIDTH    = if_types_pkg::VALUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  operation_e             req_operation_in [NUM_REQ],
  input  logic [KEY_WIDTH-1:0]   req_key_in       [NUM_REQ],
  input  logic [VALUE_WIDTH-1:0] req_value_in     [NUM_REQ],
  output logic                   req_ready_out    [NUM_REQ],
  output logic                   req_op_succ_out  [NUM_REQ],
  output logic [VALUE_WIDTH-1:0] req_value_out    [NUM_REQ],
  output logic                   req_overrun_out  [NUM_REQ],
  output operation_e             ctrl_operation_out,
  output logic [KEY_WIDTH-1:0]   ctrl_key_out,
  output logic [VALUE_WIDTH-1:0] ctrl_value_out,
  input  logic                   ctrl_ready_in,
  input  logic                   ctrl_op_succ_in,
  input  logic [VALUE_WIDTH-1:0] ctrl_value_in
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   succ_q, succ_d;
  logic [VALUE_WIDTH-1:0] rval_q, rval_d;

  logic                   slot_vld_q [NUM_REQ];
  logic                   slot_vld_d [NUM_REQ];
  operation_e             slot_op_q  [NUM_REQ];
  operation_e             slot_op_d  [NUM_REQ];
  logic [KEY_WIDTH-1:0]   slot_key_q [NUM_REQ];
  logic [KEY_WIDTH-1:0]   slot_key_d [NUM_REQ];
  logic [VALUE_WIDTH-1:0] slot_val_q [NUM_REQ];
  logic [VALUE_WIDTH-1:0] slot_val_d [NUM_REQ];
  logic                   overrun_q  [NUM_REQ];
  logic                   overrun_d  [NUM_REQ];

  logic done;
  logic found;
  int   idx;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    succ_d   = succ_q;
    rval_d   = rval_q;
    done     = 1'b0;
    found    = 1'b0;
    idx      = 0;

    case (state_q)
      S_IDLE: begin
        // Scan starting at rr_ptr so the port after the last one served goes first.
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (int'(rr_ptr_q) + k) % NUM_REQ;
          if (!found && slot_vld_q[idx]) begin
            found   = 1'b1;
            grant_d = PW'(idx);
          end
        end
        if (found) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (ctrl_ready_in) begin
          succ_d = ctrl_op_succ_in;
          rval_d = ctrl_value_in;
          done   = 1'b1;
        end else if (wd_d == WW'(TIMEOUT_CYCLES)) begin
          succ_d = 1'b0;
          rval_d = '0;
          done   = 1'b1;
        end
        if (done) begin
          rr_ptr_d = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d  = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new strobe wins over the completion clearing the same slot.
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_vld_d[i] = slot_vld_q[i];
      slot_op_d[i]  = slot_op_q[i];
      slot_key_d[i] = slot_key_q[i];
      slot_val_d[i] = slot_val_q[i];
      overrun_d[i]  = overrun_q[i];
      if (req_operation_in[i] != NOOP) begin
        if (!slot_vld_q[i] || (done && grant_q == PW'(i))) begin
          slot_vld_d[i] = 1'b1;
          slot_op_d[i]  = req_operation_in[i];
          slot_key_d[i] = req_key_in[i];
          slot_val_d[i] = req_value_in[i];
        end else begin
          overrun_d[i] = 1'b1;
        end
      end else if (done && grant_q == PW'(i)) begin
        slot_vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
      succ_q   <= 1'b0;
      rval_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_vld_q[i] <= 1'b0;
        slot_op_q[i]  <= NOOP;
        slot_key_q[i] <= '0;
        slot_val_q[i] <= '0;
        overrun_q[i]  <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q     <= wd_d;
      succ_q   <= succ_d;
      rval_q   <= rval_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_vld_q[i] <= slot_vld_d[i];
        slot_op_q[i]  <= slot_op_d[i];
        slot_key_q[i] <= slot_key_d[i];
        slot_val_q[i] <= slot_val_d[i];
        overrun_q[i]  <= overrun_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_out[i]   = (state_q == S_RESP) && (grant_q == PW'(i));
      req_op_succ_out[i] = req_ready_out[i] && succ_q;
      req_value_out[i]   = req_ready_out[i] ? rval_q : '0;
      req_overrun_out[i] = overrun_q[i];
    end
  end

  // The granted slot stays untouched until completion, so it can drive key/value directly.
  assign ctrl_operation_out = (state_q == S_ISSUE) ? slot_op_q[grant_q] : NOOP;
  assign ctrl_key_out   = (state_q == S_ISSUE || state_q == S_WAIT) ? slot_key_q[grant_q] : '0;
  assign ctrl_value_out = (state_q == S_ISSUE || state_q == S_WAIT) ? slot_val_q[grant_q] : '0;

endmodule

// File: tb/tb_cache_ctrl_arbiter.sv
// Directed bench for cache_ctrl_arbiter with two ports and a 4-cycle watchdog.
module tb_cache_ctrl_arbiter;
  import ctrl_types_pkg::*;

  localparam int N  = 2;
  localparam int KW = if_types_pkg::KEY_WIDTH;
  localparam int VW = if_types_pkg::VALUE_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  operation_e    op_in   [N];
  logic [KW-1:0] key_in  [N];
  logic [VW-1:0] val_in  [N];
  logic          rdy_out [N];
  logic          succ_out[N];
  logic [VW-1:0] val_out [N];
  logic          ovr_out [N];
  operation_e    c_op;
  logic [KW-1:0] c_key;
  logic [VW-1:0] c_val;
  logic          c_rdy = 1'b0;
  logic          c_succ = 1'b0;
  logic [VW-1:0] c_rval = '0;

  int checks = 0;
  int errors = 0;

  cache_ctrl_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_operation_in(op_in), .req_key_in(key_in), .req_value_in(val_in),
    .req_ready_out(rdy_out), .req_op_succ_out(succ_out), .req_value_out(val_out),
    .req_overrun_out(ovr_out),
    .ctrl_operation_out(c_op), .ctrl_key_out(c_key), .ctrl_value_out(c_val),
    .ctrl_ready_in(c_rdy), .ctrl_op_succ_in(c_succ), .ctrl_value_in(c_rval)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic strobe(input int p, input operation_e op, input logic [KW-1:0] k,
                        input logic [VW-1:0] v);
    op_in[p]  = op;
    key_in[p] = k;
    val_in[p] = v;
  endtask

  task automatic clear_strobes();
    for (int i = 0; i < N; i++) op_in[i] = NOOP;
  endtask

  // Starts in an IDLE cycle with the slot loaded; returns in the RESP cycle.
  task automatic serve(input int p, input logic [KW-1:0] k, input logic [VW-1:0] rv);
    step();
    chk("serve_issue_valid", 64'(c_op != NOOP), 64'(1));
    chk("serve_issue_key", 64'(c_key), 64'(k));
    step();
    c_rdy = 1'b1; c_succ = 1'b1; c_rval = rv;
    step();
    c_rdy = 1'b0; c_succ = 1'b0; c_rval = '0;
    chk("serve_rdy_own", 64'(rdy_out[p]), 64'(1));
    chk("serve_val_own", 64'(val_out[p]), 64'(rv));
    chk("serve_rdy_other", 64'(rdy_out[1-p]), 64'(0));
    chk("serve_val_other", 64'(val_out[1-p]), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      op_in[i] = NOOP; key_in[i] = '0; val_in[i] = '0;
    end

    // Reset state
    do_reset();
    chk("rst_op", 64'(c_op), 64'(NOOP));
    chk("rst_key", 64'(c_key), 64'(0));
    chk("rst_rdy0", 64'(rdy_out[0]), 64'(0));
    chk("rst_rdy1", 64'(rdy_out[1]), 64'(0));
    chk("rst_ovr0", 64'(ovr_out[0]), 64'(0));

    // Single request: strobe c0, ISSUE c2, ready c3, response c4
    strobe(0, READ, 16'h0012, 32'h0000_00AB);
    step();
    clear_strobes();
    chk("single_c1_op", 64'(c_op), 64'(NOOP));
    step();
    chk("single_c2_op", 64'(c_op), 64'(READ));
    chk("single_c2_key", 64'(c_key), 64'h12);
    chk("single_c2_val", 64'(c_val), 64'hAB);
    step();
    chk("single_c3_op", 64'(c_op), 64'(NOOP));
    chk("single_c3_key", 64'(c_key), 64'h12);
    c_rdy = 1'b1; c_succ = 1'b1; c_rval = 32'h55;
    step();
    c_rdy = 1'b0; c_succ = 1'b0; c_rval = '0;
    chk("single_c4_rdy0", 64'(rdy_out[0]), 64'(1));
    chk("single_c4_succ0", 64'(succ_out[0]), 64'(1));
    chk("single_c4_val0", 64'(val_out[0]), 64'h55);
    chk("single_c4_rdy1", 64'(rdy_out[1]), 64'(0));
    chk("single_c4_succ1", 64'(succ_out[1]), 64'(0));
    step();
    chk("single_c5_rdy0", 64'(rdy_out[0]), 64'(0));
    chk("single_c5_val0", 64'(val_out[0]), 64'(0));

    // Simultaneous requests: port0 first, then port1
    do_reset();
    strobe(0, WRITE, 16'h0021, 32'h1111);
    strobe(1, READ, 16'h0034, 32'h2222);
    step();
    clear_strobes();
    serve(0, 16'h0021, 32'hA0);
    step();
    chk("simul_idle_op", 64'(c_op), 64'(NOOP));
    step();
    chk("simul_p1_op", 64'(c_op), 64'(READ));
    chk("simul_p1_val", 64'(c_val), 64'h2222);
    step();
    c_rdy = 1'b1; c_succ = 1'b0; c_rval = 32'hB1;
    step();
    c_rdy = 1'b0; c_rval = '0;
    chk("simul_p1_rdy", 64'(rdy_out[1]), 64'(1));
    chk("simul_p1_succ", 64'(succ_out[1]), 64'(0));
    chk("simul_p1_rval", 64'(val_out[1]), 64'hB1);
    chk("simul_p0_quiet", 64'(rdy_out[0]), 64'(0));

    // Fairness: grants alternate 0,1,0,1 with port0 re-strobing at each RESP
    do_reset();
    strobe(0, READ, 16'h0100, 32'h0);
    strobe(1, WRITE, 16'h0200, 32'h0);
    step();
    clear_strobes();
    serve(0, 16'h0100, 32'h10);
    strobe(0, READ, 16'h0101, 32'h0);
    step();
    clear_strobes();
    serve(1, 16'h0200, 32'h20);
    strobe(1, WRITE, 16'h0201, 32'h0);
    step();
    clear_strobes();
    serve(0, 16'h0101, 32'h11);
    strobe(0, READ, 16'h0102, 32'h0);
    step();
    clear_strobes();
    serve(1, 16'h0201, 32'h21);

    // Timeout: no controller ready, response after the 4th WAIT cycle
    do_reset();
    strobe(0, READ, 16'h0055, 32'h0);
    step();
    clear_strobes();
    step();
    chk("to_issue_op", 64'(c_op), 64'(READ));
    for (int w = 1; w <= 4; w++) begin
      step();
      chk($sformatf("to_wait%0d_rdy", w), 64'(rdy_out[0]), 64'(0));
    end
    step();
    chk("to_rdy", 64'(rdy_out[0]), 64'(1));
    chk("to_succ", 64'(succ_out[0]), 64'(0));
    chk("to_val", 64'(val_out[0]), 64'(0));
    c_rdy = 1'b1; c_succ = 1'b1; c_rval = 32'h77;
    step();
    chk("to_late_rdy0", 64'(rdy_out[0]), 64'(0));
    chk("to_late_op", 64'(c_op), 64'(NOOP));
    step();
    c_rdy = 1'b0; c_succ = 1'b0; c_rval = '0;
    chk("to_late2_rdy0", 64'(rdy_out[0]), 64'(0));
    chk("to_late2_val0", 64'(val_out[0]), 64'(0));

    // Overrun: second strobe while pending is dropped and flag sticks
    do_reset();
    strobe(1, READ, 16'h0031, 32'h0);
    step();
    chk("ovr_before", 64'(ovr_out[1]), 64'(0));
    strobe(1, WRITE, 16'h0032, 32'h0);
    step();
    clear_strobes();
    chk("ovr_set1", 64'(ovr_out[1]), 64'(1));
    chk("ovr_port0", 64'(ovr_out[0]), 64'(0));
    chk("ovr_key_kept", 64'(c_key), 64'h31);
    chk("ovr_op_kept", 64'(c_op), 64'(READ));
    step();
    c_rdy = 1'b1; c_succ = 1'b1; c_rval = 32'h9;
    step();
    c_rdy = 1'b0; c_succ = 1'b0; c_rval = '0;
    chk("ovr_resp", 64'(rdy_out[1]), 64'(1));
    step();
    chk("ovr_sticky", 64'(ovr_out[1]), 64'(1));

    // Set over clear: strobe lands in the completion cycle of its own slot
    do_reset();
    strobe(0, READ, 16'h0040, 32'h0);
    step();
    clear_strobes();
    step();
    step();
    c_rdy = 1'b1; c_succ = 1'b1; c_rval = 32'h44;
    strobe(0, WRITE, 16'h0041, 32'h4141);
    step();
    c_rdy = 1'b0; c_succ = 1'b0; c_rval = '0;
    clear_strobes();
    chk("soc_resp", 64'(rdy_out[0]), 64'(1));
    chk("soc_no_ovr", 64'(ovr_out[0]), 64'(0));
    step();
    step();
    chk("soc_reissue_op", 64'(c_op), 64'(WRITE));
    chk("soc_reissue_key", 64'(c_key), 64'h41);
    step();
    c_rdy = 1'b1; c_succ = 1'b1; c_rval = 32'h45;
    step();
    c_rdy = 1'b0; c_succ = 1'b0; c_rval = '0;
    chk("soc_resp2_val", 64'(val_out[0]), 64'h45);

    // Reset in WAIT: outputs clear, late result ignored, fresh request works
    do_reset();
    strobe(0, READ, 16'h0060, 32'h6060);
    step();
    clear_strobes();
    step();
    step();
    chk("rw_wait_key", 64'(c_key), 64'h60);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_op", 64'(c_op), 64'(NOOP));
    chk("rw_key", 64'(c_key), 64'(0));
    chk("rw_val", 64'(c_val), 64'(0));
    chk("rw_rdy0", 64'(rdy_out[0]), 64'(0));
    c_rdy = 1'b1; c_succ = 1'b1; c_rval = 32'hDD;
    step();
    c_rdy = 1'b0; c_succ = 1'b0; c_rval = '0;
    chk("rw_late_rdy0", 64'(rdy_out[0]), 64'(0));
    chk("rw_late_val0", 64'(val_out[0]), 64'(0));
    strobe(1, DELETE, 16'h0061, 32'h0);
    step();
    clear_strobes();
    serve(1, 16'h0061, 32'hCC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
